// File: rtl/uart_tx_scheduler.sv
// Round-robin packet scheduler sharing one UART transmit path among NREQ byte-stream requesters.
// Each byte goes load -> start pulse -> wait for done; a watchdog and an inter-packet gap bound every packet.
module uart_tx_scheduler #(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 65535,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              timeout_err
);

  localparam int          TW       = $clog2(TIMEOUT);
  localparam int          GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned NR       = NREQ;
  localparam logic [TW-1:0]  TMAX     = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDW-1:0] PTR_RST  = IDW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP
  } state_e;

  localparam state_e END_ST = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     data_q, data_d;
  logic           last_q, last_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [GW-1:0]  gap_q, gap_d;

  logic           arb_found;
  logic [IDW-1:0] arb_idx;
  int unsigned    arb_cand;

  logic           sel_valid;
  logic           sel_last;
  logic [7:0]     sel_data;

  assign sel_valid = req_valid[grant_q];
  assign sel_last  = req_last[grant_q];
  assign sel_data  = req_data[{grant_q, 3'b000} +: 8];

  // Search ptr+1, ptr+2, ... with wrap; ptr < NREQ so one subtraction suffices.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = 0;
    for (int unsigned k = 1; k <= NR; k++) begin
      arb_cand = k + 32'(ptr_q);
      if (arb_cand >= NR) arb_cand = arb_cand - NR;
      if (!arb_found && req_valid[arb_cand[IDW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_LOAD) req_ready[grant_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    last_d      = last_q;
    timer_d     = '0;
    gap_d       = '0;
    tx_start    = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (sel_valid) begin
          data_d  = sel_data;
          last_d  = sel_last;
          state_d = S_START;
        end else if (timer_q == TMAX) begin
          timeout_err = 1'b1;
          ptr_d       = grant_q;
          state_d     = END_ST;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_START: begin
        tx_start = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // A done on the expiry cycle completes the byte normally.
        if (tx_done) begin
          if (last_q) begin
            ptr_d   = grant_q;
            state_d = END_ST;
          end else begin
            state_d = S_LOAD;
          end
        end else if (timer_q == TMAX) begin
          timeout_err = 1'b1;
          ptr_d       = grant_q;
          state_d     = END_ST;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      data_q  <= '0;
      last_q  <= 1'b0;
      timer_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
    end
  end

  assign tx_data  = data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requester FIFOs feed the DUT, expected (owner, byte)
// pairs are queued at stimulus time and compared on every tx_start.
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done = 1'b0;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  uart_tx_scheduler #(
    .NREQ       (NREQ),
    .GAP_CYCLES (16),
    .TIMEOUT    (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [8:0] mem [NREQ][16];
  int head [NREQ];
  int tail [NREQ];
  logic [NREQ-1:0] acc = '0;

  logic [10:0] exp_q [$];
  int start_log [$];
  int last_start_cyc  = -1000;
  int to_cnt          = 0;
  int last_to_cyc     = -1000;
  logic auto_done     = 1'b1;
  int done_dly        = 1;
  int manual_done_cyc = -1000;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  end

  always @(posedge clk) cyc++;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = (head[i] != tail[i]);
      req_data[i*8 +: 8] = mem[i][head[i][3:0]][7:0];
      req_last[i]        = mem[i][head[i][3:0]][8];
    end
  end

  always @(negedge clk) acc = req_valid & req_ready & {NREQ{!rst}};

  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (acc[i]) head[i] <= head[i] + 1;
  end

  always @(posedge clk) begin
    #1;
    tx_done = (auto_done && (cyc == last_start_cyc + done_dly)) || (cyc == manual_done_cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (tx_start) begin
      logic [10:0] e;
      last_start_cyc = cyc;
      start_log.push_back(cyc);
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_tx_data", 32'(tx_data), 32'(e[7:0]));
        chk("sb_grant", 32'(grant_id), 32'(e[10:8]));
      end
    end
    if (timeout_err) begin
      to_cnt++;
      last_to_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_neg(input int k);
    @(negedge clk);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic push_req(input int id, input logic [7:0] d, input logic l);
    mem[id][tail[id][3:0]] = {l, d};
    tail[id] = tail[id] + 1;
    exp_q.push_back({3'(id), d});
  endtask

  task automatic drain(input int maxc, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"},    32'(busy),        32'd0);
    chk({pfx, "_start"},   32'(tx_start),    32'd0);
    chk({pfx, "_data"},    32'(tx_data),     32'd0);
    chk({pfx, "_ready"},   32'(req_ready),   32'd0);
    chk({pfx, "_grant"},   32'(grant_id),    32'd0);
    chk({pfx, "_timeout"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, s, viol, h0, n;

    // Single byte from requester 2 with exact latency checks.
    auto_done = 1'b1;
    done_dly  = 10;
    do_reset();
    push_req(2, 8'h5A, 1'b1);
    t0 = cyc;
    @(negedge clk);
    chk_reset_vals("rst");
    goto_neg(t0 + 1);
    chk("t1_ready", 32'(req_ready), 32'h4);
    goto_neg(t0 + 2);
    chk("t1_start", 32'(tx_start), 32'd1);
    chk("t1_data", 32'(tx_data), 32'h5A);
    goto_neg(t0 + 12);
    chk("t1_grant", 32'(grant_id), 32'd2);
    goto_neg(t0 + 28);
    chk("t1_busy_gap", 32'(busy), 32'd1);
    chk("t1_grant_gap", 32'(grant_id), 32'd2);
    goto_neg(t0 + 29);
    chk("t1_busy_fall", 32'(busy), 32'd0);

    // All four requesters contending with single-byte packets.
    done_dly = 1;
    do_reset();
    start_log.delete();
    push_req(0, 8'hA0, 1'b1);
    push_req(1, 8'hA1, 1'b1);
    push_req(2, 8'hA2, 1'b1);
    push_req(3, 8'hA3, 1'b1);
    push_req(0, 8'hA4, 1'b1);
    push_req(1, 8'hA5, 1'b1);
    drain(400, "t2_drain");
    chk("t2_starts", 32'(start_log.size()), 32'd6);
    for (int i = 1; i < 6; i++)
      if (i < start_log.size())
        chk("t2_spacing", 32'(start_log[i] - start_log[i-1]), 32'd20);

    // Multi-byte packet holds the channel against a later requester.
    done_dly = 3;
    step();
    h0 = tail[1];
    push_req(1, 8'h11, 1'b0);
    push_req(1, 8'h22, 1'b0);
    push_req(1, 8'h33, 1'b1);
    n = 0;
    while (head[1] == h0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_acc11", 32'(head[1] - h0), 32'd1);
    step();
    push_req(0, 8'h44, 1'b1);
    viol = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      if (req_ready[0] && exp_q.size() > 1) viol++;
      n++;
    end
    chk("t3_rdy0_hold", 32'(viol), 32'd0);
    chk("t3_drain", 32'(exp_q.size()), 32'd0);

    // WAIT watchdog: no tx_done for the byte of requester 3.
    do_reset();
    auto_done = 1'b0;
    push_req(3, 8'h77, 1'b1);
    drain(50, "t4_drain_a");
    s = start_log[start_log.size() - 1];
    step();
    push_req(1, 8'h88, 1'b1);
    goto_neg(s + 101);
    chk("t4_to_cnt", 32'(to_cnt), 32'd1);
    chk("t4_to_cyc", 32'(last_to_cyc - s), 32'd100);
    auto_done = 1'b1;
    done_dly  = 2;
    drain(200, "t4_drain_b");
    chk("t4_next_start", 32'(start_log[start_log.size() - 1] - s), 32'd119);

    // LOAD watchdog: owner runs dry mid-packet, remaining byte resumes later.
    step();
    push_req(2, 8'h91, 1'b0);
    drain(200, "t4_drain_c");
    s = start_log[start_log.size() - 1];
    goto_neg(s + 104);
    chk("t4_load_to_cnt", 32'(to_cnt), 32'd2);
    chk("t4_load_to_cyc", 32'(last_to_cyc - s), 32'd102);
    step();
    push_req(2, 8'h92, 1'b1);
    drain(200, "t4_drain_d");

    // tx_done on the exact expiry cycle completes without error.
    step();
    auto_done = 1'b0;
    push_req(0, 8'h5C, 1'b1);
    drain(200, "t5_drain");
    s = start_log[start_log.size() - 1];
    manual_done_cyc = s + 100;
    goto_neg(s + 102);
    chk("t5_no_to", 32'(to_cnt), 32'd2);
    goto_neg(s + 116);
    chk("t5_busy_gap", 32'(busy), 32'd1);
    goto_neg(s + 117);
    chk("t5_busy_fall", 32'(busy), 32'd0);

    // Reset during WAIT, stray done afterwards, then fresh arbitration.
    step();
    push_req(1, 8'h66, 1'b1);
    drain(200, "t6_drain_a");
    s = start_log[start_log.size() - 1];
    goto_neg(s + 2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("t6_rst");
    manual_done_cyc = s + 6;
    viol = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx_start || req_ready != '0 || busy) viol++;
    end
    chk("t6_stray_done", 32'(viol), 32'd0);
    step();
    auto_done = 1'b1;
    done_dly  = 1;
    push_req(0, 8'hB0, 1'b1);
    push_req(2, 8'hB2, 1'b1);
    drain(200, "t6_drain_b");

    chk("to_total", 32'(to_cnt), 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
